// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit for the multicycle core on the single-port a/d/we/rd/spo/ready bus
// Ports: req/req_we/req_size/req_unsigned/req_addr/req_wdata accept one access while idle;
//        busy/done/rdata/fault/fault_cause report it; a/d/we/rd drive the bus, spo/ready answer.
module riscv_lsu #(
    parameter int DATA_W           = 32,
    parameter int BYTE_SWAP        = 1,
    parameter int ALLOW_MISALIGNED = 1,
    parameter int TIMEOUT          = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic [31:0]       a,
    output logic [DATA_W-1:0] d,
    output logic              we,
    output logic              rd,
    input  logic [DATA_W-1:0] spo,
    input  logic              ready
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FIN} state_t;
    state_t state, nxt;

    logic                     we_r, uns_r, part, fault_r;
    logic [1:0]               size_r, cause_r;
    logic [31:0]              addr_r, cnt;
    logic [DATA_W-1:0]        wdata_r, buf0, buf1, rdata_r, raw, ext;
    logic signed [DATA_W-1:0] sx;
    logic [3:0]               req_bytes, bytes;
    logic                     req_illegal, req_mis, req_bad, tout, split, last;
    logic [OW-1:0]            off;
    logic [2*NB-1:0]          lane;
    logic [2*DATA_W-1:0]      bmask, win, merged;
    logic [7:0]               sh;

    function automatic logic [DATA_W-1:0] swap(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] y;
        for (int i = 0; i < NB; i++) y[8*i +: 8] = x[8*(NB-1-i) +: 8];
        return BYTE_SWAP != 0 ? y : x;
    endfunction

    assign req_bytes   = 4'd1 << req_size;
    assign req_illegal = DATA_W == 32 && req_size == 2'd3;
    assign req_mis     = (req_addr[3:0] & (req_bytes - 4'd1)) != 4'd0;
    assign req_bad     = req_illegal || (req_mis && ALLOW_MISALIGNED == 0);

    assign bytes = 4'd1 << size_r;
    assign off   = addr_r[OW-1:0];
    assign split = 5'(off) + 5'(bytes) > 5'(NB);
    assign last  = !split || part;
    assign tout  = !ready && TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1);

    // Both part buffers form one little-endian window; stores merge only the
    // addressed lanes into it, loads extract starting at the byte offset.
    always_comb begin
        lane   = (2*NB)'((16'd1 << bytes) - 16'd1) << off;
        for (int i = 0; i < 2*NB; i++) bmask[8*i +: 8] = {8{lane[i]}};
        win    = {buf1, buf0};
        merged = (win & ~bmask) | (({{DATA_W{1'b0}}, wdata_r} << {off, 3'b0}) & bmask);
        raw    = DATA_W'(win >> {off, 3'b0});
        sh     = 8'(DATA_W) - (8'd8 << size_r);
        sx     = raw << sh;
        sx     = sx >>> sh;
        ext    = uns_r ? (raw << sh) >> sh : sx;
    end

    assign a           = {addr_r[31:OW] + (32-OW)'(part), OW'(0)};
    assign d           = swap(part ? merged[2*DATA_W-1:DATA_W] : merged[DATA_W-1:0]);
    assign rd          = state == RD_ISSUE;
    assign we          = state == WR_ISSUE;
    assign done        = state == FIN;
    assign busy        = state != IDLE && !done;
    assign fault       = done && fault_r;
    assign fault_cause = done ? cause_r : 2'd0;
    assign rdata       = done && !fault_r && !we_r ? ext : rdata_r;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (req) nxt = req_bad ? FIN : req_we && req_bytes == 4'(NB) && !req_mis ? WR_ISSUE : RD_ISSUE;
            RD_ISSUE: nxt = RD_WAIT;
            RD_WAIT:  nxt = ready ? (we_r ? WR_ISSUE : last ? FIN : RD_ISSUE) : tout ? FIN : RD_WAIT;
            WR_ISSUE: nxt = WR_WAIT;
            WR_WAIT:  nxt = ready ? (last ? FIN : RD_ISSUE) : tout ? FIN : WR_WAIT;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            size_r  <= 2'd0;
            addr_r  <= '0;
            wdata_r <= '0;
            part    <= 1'b0;
            fault_r <= 1'b0;
            cause_r <= 2'd0;
            cnt     <= '0;
            buf0    <= '0;
            buf1    <= '0;
            rdata_r <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (req) begin
                    we_r    <= req_we;
                    size_r  <= req_size;
                    uns_r   <= req_unsigned;
                    addr_r  <= req_addr;
                    wdata_r <= req_wdata;
                    part    <= 1'b0;
                    fault_r <= req_bad;
                    cause_r <= req_illegal ? 2'd3 : req_bad ? 2'd1 : 2'd0;
                end
                RD_ISSUE, WR_ISSUE: cnt <= '0;
                RD_WAIT, WR_WAIT: begin
                    if (!ready) cnt <= cnt + 32'd1;
                    if (ready && state == RD_WAIT && part) buf1 <= swap(spo);
                    if (ready && state == RD_WAIT && !part) buf0 <= swap(spo);
                    // a store advances to part 1 only after W0; a load right after R0
                    if (ready && !last && (state == WR_WAIT || !we_r)) part <= 1'b1;
                    if (tout) begin
                        fault_r <= 1'b1;
                        cause_r <= 2'd2;
                    end
                end
                FIN: if (!fault_r && !we_r) rdata_r <= ext;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed bench for riscv_lsu with a byte-swapping memory responder
module tb_riscv_lsu;
    logic        clk = 0, rst = 0;
    logic        req = 0, req2 = 0, req_we = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        busy, done, fault, we, rd, ready = 0;
    logic [1:0]  fault_cause;
    logic [31:0] rdata, a, d, spo = 0;
    logic        busy2, done2, fault2, we2, rd2;
    logic [1:0]  fc2;
    logic [31:0] rdata2, a2, d2;

    int vectors = 0, errors = 0;
    int delay = 1, bus2 = 0, wcnt = 0;
    bit stuck = 0, pend = 0, pwe = 0;
    logic [31:0] paddr, pdata;
    logic [32:0] log_q[$];
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    riscv_lsu #(.DATA_W(32), .BYTE_SWAP(1), .ALLOW_MISALIGNED(1), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
        .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready));

    riscv_lsu #(.DATA_W(32), .BYTE_SWAP(1), .ALLOW_MISALIGNED(0), .TIMEOUT(4)) dut_nomis (
        .clk(clk), .rst(rst), .req(req2), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy2), .done(done2), .rdata(rdata2), .fault(fault2), .fault_cause(fc2),
        .a(a2), .d(d2), .we(we2), .rd(rd2), .spo(32'h0), .ready(1'b0));

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] rdmem(input logic [31:0] ad);
        return mem.exists(ad) ? mem[ad] : 32'h0;
    endfunction

    always @(negedge clk) begin
        ready = 0;
        if (rst || stuck) pend = 0;
        if (!rst && (rd || we)) begin
            pend = 1; wcnt = 0; paddr = a; pwe = we; pdata = d;
            log_q.push_back({we, a});
        end else if (pend) begin
            wcnt++;
            if (wcnt == delay) begin
                ready = 1; pend = 0;
                if (pwe) mem[paddr] = swap32(pdata);
                else spo = swap32(rdmem(paddr));
            end
        end
        if (rd2 || we2) bus2++;
    end

    task automatic do_req(input bit sel, input bit w, input logic [1:0] sz, input bit u,
                          input logic [31:0] ad, input logic [31:0] wd, output int cyc,
                          output logic [31:0] rdv, output logic fv, output logic [1:0] cv, output logic bsy1);
        bit got = 0;
        @(negedge clk);
        log_q.delete();
        req_we = w; req_size = sz; req_unsigned = u; req_addr = ad; req_wdata = wd;
        if (sel) req2 = 1; else req = 1;
        cyc = 0; bsy1 = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            req = 0; req2 = 0; cyc++;
            if (cyc == 1) bsy1 = sel ? busy2 : busy;
            got = sel ? done2 : done;
        end
        vectors++; if (!got) begin errors++; $display("FAIL done_wait: done=0 after 60 cycles, required done=1"); end
        cyc++;
        rdv = sel ? rdata2 : rdata; fv = sel ? fault2 : fault; cv = sel ? fc2 : fault_cause;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", fault); end
        vectors++; if (fault_cause !== 2'd0) begin errors++; $display("FAIL rst_cause: got %0d expected 0", fault_cause); end
        vectors++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        vectors++; if (we !== 1'b0 || rd !== 1'b0) begin errors++; $display("FAIL rst_strobes: got we=%b rd=%b expected 0 0", we, rd); end
        vectors++; if (a !== 32'h0) begin errors++; $display("FAIL rst_a: got %h expected 0", a); end
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_d: got %h expected 0", d); end
    endtask

    task automatic test_aligned_load;
        int c; logic [31:0] r; logic f, b; logic [1:0] fc;
        mem[32'h100] = 32'h11223344; delay = 1;
        do_req(0, 0, 2'd2, 0, 32'h100, 0, c, r, f, fc, b);
        vectors++; if (c !== 4) begin errors++; $display("FAIL lw_latency: got %0d expected 4", c); end
        vectors++; if (r !== 32'h11223344) begin errors++; $display("FAIL lw_rdata: got %h expected 11223344", r); end
        vectors++; if (f !== 1'b0) begin errors++; $display("FAIL lw_fault: got %b expected 0", f); end
        vectors++; if (b !== 1'b1) begin errors++; $display("FAIL lw_busy_issue: got %b expected 1", b); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL lw_busy_fin: got %b expected 0", busy); end
        vectors++; if (log_q.size() != 1 || log_q[0] !== {1'b0, 32'h100}) begin errors++; $display("FAIL lw_bus: got %0d ops first %h expected 1 op 0_00000100", log_q.size(), log_q[0]); end
        @(negedge clk);
        vectors++; if (rdata !== 32'h11223344 || done !== 1'b0) begin errors++; $display("FAIL lw_hold: got rdata=%h done=%b expected 11223344 0", rdata, done); end
    endtask

    task automatic test_subword_store;
        int c; logic [31:0] r; logic f, b; logic [1:0] fc;
        delay = 3;
        do_req(0, 1, 2'd0, 0, 32'h102, 32'h000000AB, c, r, f, fc, b);
        vectors++; if (rdmem(32'h100) !== 32'h11AB3344) begin errors++; $display("FAIL sb_mem: got %h expected 11ab3344", rdmem(32'h100)); end
        vectors++; if (c !== 10) begin errors++; $display("FAIL sb_latency: got %0d expected 10", c); end
        vectors++; if (log_q.size() != 2 || log_q[0] !== {1'b0, 32'h100} || log_q[1] !== {1'b1, 32'h100}) begin errors++; $display("FAIL sb_bus: got %0d ops expected R100 W100", log_q.size()); end
        vectors++; if (f !== 1'b0) begin errors++; $display("FAIL sb_fault: got %b expected 0", f); end
        delay = 1;
        do_req(0, 0, 2'd0, 0, 32'h102, 0, c, r, f, fc, b);
        vectors++; if (r !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb_sign: got %h expected ffffffab", r); end
        do_req(0, 0, 2'd0, 1, 32'h102, 0, c, r, f, fc, b);
        vectors++; if (r !== 32'h000000AB) begin errors++; $display("FAIL lbu_zero: got %h expected 000000ab", r); end
        do_req(0, 1, 2'd1, 0, 32'h100, 32'hFFFF5A5A, c, r, f, fc, b);
        vectors++; if (rdmem(32'h100) !== 32'h11AB5A5A) begin errors++; $display("FAIL sh_mem: got %h expected 11ab5a5a", rdmem(32'h100)); end
        vectors++; if (c !== 6) begin errors++; $display("FAIL sh_latency: got %0d expected 6", c); end
    endtask

    task automatic test_aligned_store;
        int c; logic [31:0] r; logic f, b; logic [1:0] fc;
        do_req(0, 1, 2'd2, 0, 32'h10C, 32'h01020304, c, r, f, fc, b);
        vectors++; if (rdmem(32'h10C) !== 32'h01020304) begin errors++; $display("FAIL sw_mem: got %h expected 01020304", rdmem(32'h10C)); end
        vectors++; if (c !== 4) begin errors++; $display("FAIL sw_latency: got %0d expected 4", c); end
        vectors++; if (log_q.size() != 1 || log_q[0] !== {1'b1, 32'h10C}) begin errors++; $display("FAIL sw_bus: got %0d ops expected W10C only", log_q.size()); end
    endtask

    task automatic test_split_load;
        int c; logic [31:0] r; logic f, b; logic [1:0] fc;
        mem[32'h100] = 32'h80FFFFFF; mem[32'h104] = 32'hFFFFFF00;
        do_req(0, 0, 2'd1, 1, 32'h103, 0, c, r, f, fc, b);
        vectors++; if (r !== 32'h00000080) begin errors++; $display("FAIL lhu_split: got %h expected 00000080", r); end
        vectors++; if (c !== 6) begin errors++; $display("FAIL lh_split_latency: got %0d expected 6", c); end
        vectors++; if (log_q.size() != 2 || log_q[0] !== {1'b0, 32'h100} || log_q[1] !== {1'b0, 32'h104}) begin errors++; $display("FAIL lh_split_bus: got %0d ops expected R100 R104", log_q.size()); end
        do_req(0, 0, 2'd1, 0, 32'h103, 0, c, r, f, fc, b);
        vectors++; if (r !== 32'h00000080) begin errors++; $display("FAIL lh_split_pos: got %h expected 00000080", r); end
        mem[32'h100] = 32'h00FFFFFF; mem[32'h104] = 32'hFFFFFF80;
        do_req(0, 0, 2'd1, 0, 32'h103, 0, c, r, f, fc, b);
        vectors++; if (r !== 32'hFFFF8000) begin errors++; $display("FAIL lh_split_neg: got %h expected ffff8000", r); end
        do_req(0, 0, 2'd1, 1, 32'h103, 0, c, r, f, fc, b);
        vectors++; if (r !== 32'h00008000) begin errors++; $display("FAIL lhu_split_neg: got %h expected 00008000", r); end
    endtask

    task automatic test_split_store;
        int c; logic [31:0] r; logic f, b; logic [1:0] fc;
        mem[32'h100] = 32'h11223344; mem[32'h104] = 32'h55667788;
        do_req(0, 1, 2'd2, 0, 32'h102, 32'hDEADBEEF, c, r, f, fc, b);
        vectors++; if (rdmem(32'h100) !== 32'hBEEF3344) begin errors++; $display("FAIL ssw_mem0: got %h expected beef3344", rdmem(32'h100)); end
        vectors++; if (rdmem(32'h104) !== 32'h5566DEAD) begin errors++; $display("FAIL ssw_mem1: got %h expected 5566dead", rdmem(32'h104)); end
        vectors++; if (c !== 10) begin errors++; $display("FAIL ssw_latency: got %0d expected 10", c); end
        vectors++; if (log_q.size() != 4 || log_q[0] !== {1'b0, 32'h100} || log_q[1] !== {1'b1, 32'h100}
                       || log_q[2] !== {1'b0, 32'h104} || log_q[3] !== {1'b1, 32'h104}) begin errors++; $display("FAIL ssw_order: got %0d ops expected R100 W100 R104 W104", log_q.size()); end
    endtask

    task automatic test_faults;
        int c, n0; logic [31:0] r; logic f, b; logic [1:0] fc;
        do_req(0, 0, 2'd3, 0, 32'h100, 0, c, r, f, fc, b);
        vectors++; if (f !== 1'b1 || fc !== 2'd3) begin errors++; $display("FAIL illegal_size: got fault=%b cause=%0d expected 1 3", f, fc); end
        vectors++; if (c !== 2 || log_q.size() != 0) begin errors++; $display("FAIL illegal_timing: got %0d cycles %0d ops expected 2 0", c, log_q.size()); end
        n0 = bus2;
        do_req(1, 0, 2'd1, 0, 32'h103, 0, c, r, f, fc, b);
        vectors++; if (f !== 1'b1 || fc !== 2'd1) begin errors++; $display("FAIL misalign_fault: got fault=%b cause=%0d expected 1 1", f, fc); end
        vectors++; if (c !== 2) begin errors++; $display("FAIL misalign_latency: got %0d expected 2", c); end
        vectors++; if (bus2 !== n0) begin errors++; $display("FAIL misalign_bus: got %0d strobes expected 0", bus2 - n0); end
    endtask

    task automatic test_timeout;
        int c; logic [31:0] r; logic f, b; logic [1:0] fc;
        mem[32'h108] = 32'hA5A51234;
        do_req(0, 0, 2'd2, 0, 32'h108, 0, c, r, f, fc, b);
        stuck = 1;
        do_req(0, 0, 2'd2, 0, 32'h10C, 0, c, r, f, fc, b);
        vectors++; if (f !== 1'b1 || fc !== 2'd2) begin errors++; $display("FAIL tout_fault: got fault=%b cause=%0d expected 1 2", f, fc); end
        vectors++; if (c !== 7) begin errors++; $display("FAIL tout_latency: got %0d expected 7", c); end
        vectors++; if (r !== 32'hA5A51234) begin errors++; $display("FAIL tout_rdata: got %h expected a5a51234", r); end
        vectors++; if (log_q.size() != 1) begin errors++; $display("FAIL tout_bus: got %0d ops expected 1", log_q.size()); end
        stuck = 0;
        do_req(0, 0, 2'd2, 0, 32'h10C, 0, c, r, f, fc, b);
        vectors++; if (f !== 1'b0 || r !== 32'h01020304) begin errors++; $display("FAIL tout_recover: got fault=%b rdata=%h expected 0 01020304", f, r); end
    endtask

    task automatic test_reset_mid;
        int c; logic [31:0] r; logic f, b; logic [1:0] fc; bit dn = 0;
        mem[32'h100] = 32'h11223344; mem[32'h104] = 32'h55667788; delay = 3;
        @(negedge clk);
        req_we = 1; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h102; req_wdata = 32'hCAFEF00D; req = 1;
        @(negedge clk);
        req = 0;
        vectors++; if (rd !== 1'b1) begin errors++; $display("FAIL rmid_issue: got rd=%b expected 1", rd); end
        @(negedge clk);
        rst = 1;
        #1;
        vectors++; if (rd !== 1'b0 || we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_drop: got rd=%b we=%b busy=%b expected 0 0 0", rd, we, busy); end
        vectors++; if (a !== 32'h0) begin errors++; $display("FAIL rmid_a: got %h expected 0", a); end
        repeat (3) begin @(negedge clk); dn |= done; end
        rst = 0;
        repeat (4) begin @(negedge clk); dn |= done; end
        vectors++; if (dn !== 1'b0) begin errors++; $display("FAIL rmid_done: got a done pulse expected none"); end
        vectors++; if (rdmem(32'h100) !== 32'h11223344 || rdmem(32'h104) !== 32'h55667788) begin errors++; $display("FAIL rmid_mem: got %h %h expected 11223344 55667788", rdmem(32'h100), rdmem(32'h104)); end
        delay = 1;
        do_req(0, 0, 2'd2, 0, 32'h100, 0, c, r, f, fc, b);
        vectors++; if (r !== 32'h11223344 || f !== 1'b0 || c !== 4) begin errors++; $display("FAIL rmid_next: got rdata=%h fault=%b cycles=%0d expected 11223344 0 4", r, f, c); end
    endtask

    initial begin
        test_reset;
        test_aligned_load;
        test_subword_store;
        test_aligned_store;
        test_split_load;
        test_split_store;
        test_faults;
        test_timeout;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1);
    end
endmodule
